// File: rtl/imem_pkg.sv
// Shared definitions for the byte-addressed instruction memory: writer FSM
// states, word geometry and the big-endian byte order used on both sides.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        WRITE,
        DONE
    } imem_wr_state_t;

    localparam int BYTES_PER_WORD = 4;

    // Byte k of a word in memory order: byte 0 is the most significant.
    function automatic logic [7:0] be_byte(input logic [31:0] word, input logic [1:0] k);
        logic [7:0] b;
        case (k)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/imem_byte_writer.sv
// Loader-side writer for the instruction memory. Each 32-bit word taken from
// the stream becomes four consecutive big-endian byte writes; the core is held
// off (busy) for the whole session.
module imem_byte_writer
    import imem_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int ADDR_W      = 32,
    parameter int CNT_W       = $clog2(DEPTH_BYTES) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              word_valid,
    input  logic [31:0]       word_data,
    input  logic              word_last,
    output logic              word_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [7:0]        wdata,
    output logic              busy,
    output logic              done,
    output logic              err_align,
    output logic              err_overflow,
    output logic [CNT_W-1:0]  bytes_written
);

    imem_wr_state_t    state;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        k;
    logic [31:0]       word_q;
    logic              last_q;

    // Last byte of the word about to be written, one bit wider so that an
    // address wrapping past 2^ADDR_W still reads as out of range.
    logic [ADDR_W:0] end_addr;
    logic            word_ovf;

    assign end_addr = {1'b0, addr} + (ADDR_W+1)'(BYTES_PER_WORD - 1);
    assign word_ovf = end_addr > (ADDR_W+1)'(DEPTH_BYTES - 1);

    // Session FSM with registered write port and status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            addr          <= '0;
            k             <= '0;
            we            <= 1'b0;
            waddr         <= '0;
            wdata         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            word_ready    <= 1'b0;
            err_align     <= 1'b0;
            err_overflow  <= 1'b0;
            bytes_written <= '0;
        end else begin
            we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (base_addr[1:0] != 2'b00) begin
                            err_align <= 1'b1;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            addr          <= base_addr;
                            err_align     <= 1'b0;
                            err_overflow  <= 1'b0;
                            done          <= 1'b0;
                            bytes_written <= '0;
                            busy          <= 1'b1;
                            word_ready    <= 1'b1;
                            state         <= ARMED;
                        end
                    end
                end
                ARMED: begin
                    if (word_valid && word_ready) begin
                        word_ready <= 1'b0;
                        if (word_ovf) begin
                            err_overflow <= 1'b1;
                            done         <= 1'b1;
                            busy         <= 1'b0;
                            state        <= DONE;
                        end else begin
                            // Byte 0 goes out straight from the stream so the
                            // first write lands the cycle after the handshake.
                            we            <= 1'b1;
                            waddr         <= addr;
                            wdata         <= be_byte(word_data, 2'd0);
                            bytes_written <= bytes_written + CNT_W'(1);
                            k             <= 2'd0;
                            state         <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    // k is the byte currently on the port.
                    if (k != 2'd3) begin
                        we            <= 1'b1;
                        waddr         <= addr + ADDR_W'(k) + ADDR_W'(1);
                        wdata         <= be_byte(word_q, k + 2'd1);
                        bytes_written <= bytes_written + CNT_W'(1);
                        k             <= k + 2'd1;
                    end else begin
                        k    <= 2'd0;
                        addr <= addr + ADDR_W'(BYTES_PER_WORD);
                        if (last_q) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end else begin
                            word_ready <= 1'b1;
                            state      <= ARMED;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Captured word and its last flag; pure data, only loaded on a handshake.
    always_ff @(posedge clk) begin
        if (state == ARMED && word_valid && word_ready) begin
            word_q <= word_data;
            last_q <= word_last;
        end
    end

endmodule
